muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 197 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: RV32M multiply/divide unit with a direct register-file write port.
// Divides run a restoring shift-subtract over operand magnitudes, one quotient
// bit per cycle. Divide-by-zero, signed overflow and multiplies finish early.
// Optional feature macro: MULDIV_MUL_EN compiles in the multiply ops. Without
// it, ops 000-011 complete early and are flagged as illegal.
//
// Handshake: start is a single-cycle request taken only while busy=0, on the
// rising edge where start=1. There is no ready/backpressure; the result is
// presented for exactly one cycle while done=1, together with we, writeaddr
// and writedata. start is dropped in any cycle where busy=1.
//
// Latency, counted from the accepting edge E0: the first busy cycle is a setup
// cycle that converts operands to magnitudes and detects the early cases. Early
// cases show done in the cycle after E0+1. A normal divide iterates on edges
// E0+2..E0+33 and shows done in the cycle after E0+33.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [4:0]  rd_addr,
  output logic        busy,
  output logic        done,
  output logic        illegal,
  output logic        we,
  output logic [4:0]  writeaddr,
  output logic [31:0] writedata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] quot_q, quot_d;   // rs1 on capture, then dividend magnitude / quotient
  logic [31:0] rem_q, rem_d;     // partial remainder
  logic [31:0] dvs_q, dvs_d;     // rs2 on capture, then divisor magnitude
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic        ill_q, ill_d;

  logic        signed_op;
  logic        a_neg;
  logic        b_neg;
  logic [32:0] shifted;
  logic        ge;
  logic [31:0] result;
  logic [31:0] mul_res;

`ifdef MULDIV_MUL_EN
  logic        mul_sa;
  logic        mul_sb;
  logic [63:0] prod;

  // Multiply: extend each operand by its own signedness, keep the low 64 bits
  always_comb begin
    mul_sa  = (op_q[1:0] != 2'b11) & quot_q[31];
    mul_sb  = (op_q[1:0] == 2'b01) & dvs_q[31];
    prod    = {{32{mul_sa}}, quot_q} * {{32{mul_sb}}, dvs_q};
    mul_res = (op_q[1:0] == 2'b00) ? prod[31:0] : prod[63:32];
  end
`else
  // Multiply ops are not compiled in; the result value is never written
  always_comb begin
    mul_res = 32'h0;
  end
`endif

  // Divider datapath: signedness, one restoring step, final sign fix-up
  always_comb begin
    signed_op = ~op_q[0];
    a_neg     = signed_op & quot_q[31];
    b_neg     = signed_op & dvs_q[31];
    shifted   = {rem_q, quot_q[31]};
    ge        = (shifted >= {1'b0, dvs_q});
    if (op_q[1]) result = rneg_q ? (32'h0 - rem_q) : rem_q;
    else         result = qneg_q ? (32'h0 - quot_q) : quot_q;
  end

  // Next-state and datapath register updates
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    rd_d    = rd_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    ill_d   = ill_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          rd_d    = rd_addr;
          quot_d  = rs1_data;
          dvs_d   = rs2_data;
          rem_d   = 32'h0;
          cnt_d   = 6'd0;
          qneg_d  = 1'b0;
          rneg_d  = 1'b0;
          ill_d   = 1'b0;
          state_d = S_DIV;
        end
      end
      S_DIV: begin
        if (cnt_q == 6'd0) begin
          // Setup cycle: early cases load quot/rem with the final unsigned
          // values and leave the sign flags clear
          if (!op_q[2]) begin
`ifdef MULDIV_MUL_EN
            quot_d = mul_res;
            rem_d  = mul_res;
`else
            ill_d  = 1'b1;
            quot_d = 32'h0;
            rem_d  = 32'h0;
`endif
            state_d = S_DONE;
          end else if (dvs_q == 32'h0) begin
            quot_d  = 32'hFFFF_FFFF;
            rem_d   = quot_q;
            state_d = S_DONE;
          end else if (signed_op && (quot_q == 32'h8000_0000) && (dvs_q == 32'hFFFF_FFFF)) begin
            quot_d  = 32'h8000_0000;
            rem_d   = 32'h0;
            state_d = S_DONE;
          end else begin
            quot_d = a_neg ? (32'h0 - quot_q) : quot_q;
            dvs_d  = b_neg ? (32'h0 - dvs_q) : dvs_q;
            rem_d  = 32'h0;
            qneg_d = a_neg ^ b_neg;
            rneg_d = a_neg;
            cnt_d  = 6'd1;
          end
        end else begin
          quot_d = {quot_q[30:0], ge};
          rem_d  = ge ? (shifted[31:0] - dvs_q) : shifted[31:0];
          cnt_d  = cnt_q + 6'd1;
          if (cnt_q == 6'd32) state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 6'd0;
      op_q    <= 3'd0;
      rd_q    <= 5'd0;
      quot_q  <= 32'h0;
      rem_q   <= 32'h0;
      dvs_q   <= 32'h0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      ill_q   <= ill_d;
    end
  end

  // Outputs decoded from state; everything except busy is quiet outside DONE
  always_comb begin
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    illegal   = done & ill_q;
    we        = done & ~ill_q & (rd_q != 5'd0);
    writeaddr = done ? rd_q : 5'd0;
    writedata = (done & ~ill_q) ? result : 32'h0;
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit. Works with or without MULDIV_MUL_EN.
// Expected records {latency, illegal, we, writeaddr, writedata} are pushed to
// exp_q when an op is issued and popped when the op completes.
module tb_muldiv_unit;

  localparam int W = 45;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [4:0]  rd_addr;
  logic        busy;
  logic        done;
  logic        illegal;
  logic        we;
  logic [4:0]  writeaddr;
  logic [31:0] writedata;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];

  muldiv_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .rd_addr   (rd_addr),
    .busy      (busy),
    .done      (done),
    .illegal   (illegal),
    .we        (we),
    .writeaddr (writeaddr),
    .writedata (writedata)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus tables
  logic [2:0]  div_op [0:5] = '{3'b101, 3'b111, 3'b100, 3'b110, 3'b100, 3'b110};
  logic [31:0] div_a  [0:5] = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000};
  logic [31:0] div_b  [0:5] = '{32'd7, 32'd7, 32'd2, 32'd2, 32'hFFFF_FFFE, 32'd3};

  logic [2:0]  fp_op  [0:5] = '{3'b101, 3'b111, 3'b100, 3'b110, 3'b100, 3'b110};
  logic [31:0] fp_a   [0:5] = '{32'h1234, 32'h1234, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFB};
  logic [31:0] fp_b   [0:5] = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0};

  logic [2:0]  mul_op [0:3] = '{3'b011, 3'b000, 3'b001, 3'b010};
  logic [31:0] mul_a  [0:3] = '{32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
  logic [31:0] mul_b  [0:3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd3, 32'hFFFF_FFFF};

  // Reference model: architectural RV32M results written with language operators
  function automatic logic [W-1:0] exp_of(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] rd);
    logic [31:0]        wd;
    logic [31:0]        q;
    logic [31:0]        r;
    logic [5:0]         lat;
    logic               ill;
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    longint             ia;
    longint             ib;
    longint             p;
    logic [63:0]        pu;
    sa  = a;
    sb  = b;
    ia  = longint'(sa);
    ib  = longint'(sb);
    lat = 6'd1;
    ill = 1'b0;
    wd  = 32'h0;
    if (!o[2]) begin
`ifdef MULDIV_MUL_EN
      pu = {32'h0, a} * {32'h0, b};
      case (o[1:0])
        2'b00:   wd = pu[31:0];
        2'b01:   begin p = ia * ib;             wd = p[63:32]; end
        2'b10:   begin p = ia * longint'(b);    wd = p[63:32]; end
        default: wd = pu[63:32];
      endcase
`else
      pu  = 64'h0;
      p   = 0;
      ill = 1'b1;
`endif
    end else begin
      if (b == 32'h0) begin
        q = 32'hFFFF_FFFF;
        r = a;
      end else if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'h0;
      end else begin
        lat = 6'd33;
        if (!o[0]) begin
          q = sa / sb;
          r = sa % sb;
        end else begin
          q = a / b;
          r = a % b;
        end
      end
      wd = o[1] ? r : q;
    end
    return {lat, ill, (!ill && rd != 5'd0), rd, wd};
  endfunction

  // Driver: issue one op at a negedge, scramble inputs after the accepting
  // edge, then watch for done. Returns the observed record and a count of
  // protocol violations (busy low while in flight, stray outputs, extra done).
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input bit spam, input int tail,
                        output logic [W-1:0] obs, output int bad);
    bit got;
    bad      = 0;
    got      = 1'b0;
    obs      = '1;
    start    = 1'b1;
    op       = o;
    rs1_data = a;
    rs2_data = b;
    rd_addr  = rd;
    @(posedge clk);
    #1;
    start    = spam;
    op       = 3'($urandom);
    rs1_data = $urandom;
    rs2_data = $urandom;
    rd_addr  = 5'($urandom);
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      if (!busy) bad++;
      if (done) begin
        got   = 1'b1;
        obs   = {k[5:0], illegal, we, writeaddr, writedata};
        start = 1'b0;
      end else if (we || illegal || writedata != 32'h0) begin
        bad++;
      end
    end
    start = 1'b0;
    if (!got) bad++;
    for (int t = 0; t < tail; t++) begin
      @(negedge clk);
      if (done || we || illegal || writedata != 32'h0) bad++;
      if (t == 0 && busy) bad++;
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    start    = 1'b1;
    op       = 3'b101;
    rs1_data = 32'd100;
    rs2_data = 32'd7;
    rd_addr  = 5'd5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, illegal, we, writeaddr, writedata} !== 41'h0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", {busy, done, illegal, we, writeaddr, writedata});
    end
    rst_n = 1'b1;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, illegal, we, writeaddr, writedata} !== 41'h0) begin
      failures++;
      $display("FAIL reset_release_idle got=%h exp=0", {busy, done, illegal, we, writeaddr, writedata});
    end
  endtask

  task automatic test_divide();
    logic [W-1:0] obs;
    logic [W-1:0] e;
    logic [2:0]   o;
    logic [31:0]  a;
    logic [31:0]  b;
    int           bad;
    for (int i = 0; i < 10; i++) begin
      if (i < 6) begin
        o = div_op[i];
        a = div_a[i];
        b = div_b[i];
      end else begin
        o = {1'b1, 2'($urandom_range(0, 3))};
        a = $urandom;
        b = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
        if (b == 32'h0) b = 32'd3;
      end
      exp_q.push_back(exp_of(o, a, b, 5'd5));
      run_op(o, a, b, 5'd5, 1'b0, 1, obs, bad);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL divide[%0d] got=%h exp=%h", i, obs, e);
      end
      checks++;
      if (bad != 0) begin
        failures++;
        $display("FAIL divide_protocol[%0d] violations=%0d exp=0", i, bad);
      end
    end
  endtask

  task automatic test_fast_path();
    logic [W-1:0] obs;
    logic [W-1:0] e;
    int           bad;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(exp_of(fp_op[i], fp_a[i], fp_b[i], 5'd9));
      run_op(fp_op[i], fp_a[i], fp_b[i], 5'd9, 1'b0, 1, obs, bad);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL fast_path[%0d] got=%h exp=%h", i, obs, e);
      end
      checks++;
      if (bad != 0) begin
        failures++;
        $display("FAIL fast_path_protocol[%0d] violations=%0d exp=0", i, bad);
      end
    end
  endtask

  task automatic test_rd_zero();
    logic [W-1:0] obs;
    logic [W-1:0] e;
    int           bad;
    exp_q.push_back(exp_of(3'b101, 32'd100, 32'd7, 5'd0));
    run_op(3'b101, 32'd100, 32'd7, 5'd0, 1'b0, 1, obs, bad);
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL rd_zero got=%h exp=%h", obs, e);
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL rd_zero_protocol violations=%0d exp=0", bad);
    end
  endtask

  task automatic test_busy_start();
    logic [W-1:0] obs;
    logic [W-1:0] e;
    int           bad;
    exp_q.push_back(exp_of(3'b101, 32'd100, 32'd7, 5'd3));
    run_op(3'b101, 32'd100, 32'd7, 5'd3, 1'b1, 40, obs, bad);
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL busy_start got=%h exp=%h", obs, e);
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL busy_start_extra violations=%0d exp=0", bad);
    end
  endtask

  task automatic test_mid_reset();
    int we_cnt;
    we_cnt   = 0;
    start    = 1'b1;
    op       = 3'b101;
    rs1_data = 32'd100;
    rs2_data = 32'd7;
    rd_addr  = 5'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_busy got=%b exp=0", busy);
    end
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (we || done) we_cnt++;
    end
    checks++;
    if (we_cnt != 0) begin
      failures++;
      $display("FAIL mid_reset_we got=%0d exp=0", we_cnt);
    end
  endtask

  task automatic test_mul();
    logic [W-1:0] obs;
    logic [W-1:0] e;
    int           bad;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(exp_of(mul_op[i], mul_a[i], mul_b[i], 5'd12));
      run_op(mul_op[i], mul_a[i], mul_b[i], 5'd12, 1'b0, 1, obs, bad);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL mul[%0d] got=%h exp=%h", i, obs, e);
      end
      checks++;
      if (bad != 0) begin
        failures++;
        $display("FAIL mul_protocol[%0d] violations=%0d exp=0", i, bad);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] obs;
    logic [W-1:0] e;
    logic [2:0]   o;
    logic [31:0]  a;
    logic [31:0]  b;
    logic [4:0]   rd;
    int           bad;
    for (int i = 0; i < 6; i++) begin
      o  = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = (i == 2) ? 32'h0 : 32'($urandom_range(1, 50000));
      rd = 5'($urandom_range(0, 31));
      exp_q.push_back(exp_of(o, a, b, rd));
      run_op(o, a, b, rd, 1'b0, 1, obs, bad);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL back_to_back[%0d] op=%0d got=%h exp=%h", i, o, obs, e);
      end
      checks++;
      if (bad != 0) begin
        failures++;
        $display("FAIL back_to_back_protocol[%0d] violations=%0d exp=0", i, bad);
      end
    end
  endtask

  initial begin
    test_reset();
    test_divide();
    test_fast_path();
    test_rd_zero();
    test_busy_start();
    test_mid_reset();
    test_mul();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
